sar_search: RTL and testbench
=============================

# sar_search

Sequential binary-search (successive-approximation) controller that drives the probe operand of the team's 4-bit magnitude `comparator` and consumes its `agb`/`aeb`/`alb` flags. It locates an unknown target value presented on the comparator's `a` input. The block sits on the `b` side of the comparator: `probe` connects to `b`, and the comparator outputs feed back into this block. It finds the target in at most WIDTH+1 probe cycles and reports the value, the probe count and a found flag.

## Interface
- `WIDTH`, default 4: operand width. It must match the comparator. Legal range is 2..16.
- `CW`, default `$clog2(WIDTH+2)`: width of the step counter. It is a derived parameter and must not be overridden.
- `clk`: input, 1 bit. Single clock. All state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `start`: input, 1 bit. Request to begin a search. Sampled only in IDLE.
- `agb`: input, 1 bit. From the comparator: target greater than `probe`.
- `aeb`: input, 1 bit. From the comparator: target equal to `probe`.
- `alb`: input, 1 bit. From the comparator: target less than `probe`.
- `probe`: output, WIDTH bits. Registered value driven to the comparator `b` input.
- `busy`: output, 1 bit. High while in SEARCH.
- `done`: output, 1 bit. One-cycle pulse when a search terminates.
- `found`: output, 1 bit. The last search ended on `aeb`. Held until the next start.
- `result`: output, WIDTH bits. Matched value when `found`=1, 0 otherwise. Held until the next start.
- `steps`: output, CW bits. Number of probes evaluated by the last or current search.
- `err`: output, 1 bit. Flag-consistency error. Held until the next start. Tied to 0 without the macro.

## Operation
- Internal bounds `lo` and `hi` are WIDTH bits each. Midpoint = (lo+hi)>>1, computed at WIDTH+1 bits so the sum cannot overflow.
- FSM states are IDLE, SEARCH and DONE. The reset state is IDLE.
- IDLE with `start`=1:
  - lo=0, hi=2^WIDTH-1, probe=2^(WIDTH-1)-1.
  - steps=0; found, result and err are cleared.
  - Go to SEARCH.
- IDLE with `start`=0: hold all outputs.
- SEARCH: sample the flags at every edge and increment steps by 1. Then:
  - `aeb`: result=probe, found=1, go to DONE.
  - `agb`: if probe==hi, go to DONE with found=0. Otherwise lo=probe+1, probe=mid(probe+1,hi), stay in SEARCH.
  - `alb`: if probe==lo, go to DONE with found=0. Otherwise hi=probe-1, probe=mid(lo,probe-1), stay in SEARCH.
- DONE: `done`=1 for exactly this cycle, then return to IDLE unconditionally.
- `start` is ignored in SEARCH and DONE. There is no queueing.
- `probe` holds its last value in IDLE and DONE.
- Reset values: all outputs are 0 and the state is IDLE. An `rst_n` assertion mid-search aborts immediately, with no `done` pulse.
- With a consistent comparator, a search always ends with found=1 and steps ≤ WIDTH+1.

## Timing
- Edge E0 samples `start`. In the cycle after E0, busy=1 and probe is valid. The comparator is combinational, so its flags settle within the same cycle.
- Edge Ek (k≥1) samples the flags for the k-th probe. The next probe, if any, is valid in the cycle after Ek.
- On termination at Ek, `done`=1 and busy=0 during the cycle after Ek. The results are valid at the same time and stay valid afterwards.
- Latency from start to done is N+1 edges, where N is the probe count.
- Back-to-back searches: the earliest accepted `start` is the IDLE cycle that follows `done`.

## Configuration
- Macro: `SAR_SEARCH_CHK_EN`.
- Defined: at every SEARCH sampling edge, the flags must be exactly one-hot. If they are not (zero or several flags set), the search terminates: go to DONE with found=0, result=0, err=1, and steps counts the offending probe.
- Undefined: `err` is tied to 0. Flag priority is `aeb` > `agb` > `alb`, and all-zero flags are treated as `alb`.

## Test plan
- Reset, then release with start=0 → all outputs stay 0 and probe=0 for 10 cycles.
- WIDTH=4, target 7 → probe sequence 7; at the 2nd edge after start: done=1, found=1, result=7, steps=1.
- Target 15 → probe sequence 7,11,13,14,15; done at the 6th edge, result=15, steps=5.
- Target 0 → probe sequence 7,3,1,0; done at the 5th edge, result=0, steps=4. Also pulse `start` during the search → it is ignored and the sequence is unchanged.
- Target 9: assert rst_n=0 asynchronously after the 2nd probe → outputs clear immediately and no `done` pulse occurs. Restart → probe sequence 7,11,9, result=9, steps=3.
- Force agb=alb=1 on the first probe:
  - With `SAR_SEARCH_CHK_EN` → done at the 2nd edge, err=1, found=0, steps=1.
  - Without the macro → the flags are treated as `agb` and the next probe is 11.

Source files
------------

// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search driving a magnitude comparator
//
// Purpose: binary-searches the unknown value on the comparator's a input by
// driving its b input (probe) and reading back agb/aeb/alb each cycle.
// Optional macro: SAR_SEARCH_CHK_EN enables one-hot flag checking and err.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a search (sampled only while idle)
//   agb, aeb, alb     comparator flags (target >, ==, < probe)
//   probe             registered operand for the comparator b input
//   busy              high while searching
//   done              one-cycle pulse when a search terminates
//   found             last search ended on aeb (held until next start)
//   result            matched value when found, else 0 (held)
//   steps             probes evaluated by the last/current search
//   err               inconsistent flags seen (0 unless SAR_SEARCH_CHK_EN)

module sar_search #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             agb,
  input  logic             aeb,
  input  logic             alb,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    steps,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    steps_q, steps_d;
  logic             found_q, found_d;
`ifdef SAR_SEARCH_CHK_EN
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
`ifdef SAR_SEARCH_CHK_EN
    err_d    = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = '1;
          // Midpoint of the full range: 2^(WIDTH-1)-1.
          probe_d  = {1'b0, {(WIDTH-1){1'b1}}};
          steps_d  = '0;
          found_d  = 1'b0;
          result_d = '0;
`ifdef SAR_SEARCH_CHK_EN
          err_d    = 1'b0;
`endif
          state_d  = S_SEARCH;
        end
      end

      S_SEARCH: begin
        steps_d = steps_q + CW'(1);
`ifdef SAR_SEARCH_CHK_EN
        if (!$onehot({agb, aeb, alb})) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else
`endif
        if (aeb) begin
          result_d = probe_q;
          found_d  = 1'b1;
          state_d  = S_DONE;
        end else if (agb) begin
          if (probe_q == hi_q) begin
            state_d = S_DONE;
          end else begin
            lo_d    = probe_q + WIDTH'(1);
            // Sum taken one bit wider so lo+hi cannot wrap.
            probe_d = WIDTH'(({1'b0, probe_q} + (WIDTH+1)'(1) + {1'b0, hi_q}) >> 1);
          end
        end else if (alb || !(aeb || agb)) begin
          // alb, or no flag at all, both narrow the upper bound.
          if (probe_q == lo_q) begin
            state_d = S_DONE;
          end else begin
            hi_d    = probe_q - WIDTH'(1);
            // probe_q > lo_q here, so the subtraction cannot underflow.
            probe_d = WIDTH'(({1'b0, lo_q} + {1'b0, probe_q} - (WIDTH+1)'(1)) >> 1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
`ifdef SAR_SEARCH_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
`ifdef SAR_SEARCH_CHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign probe  = probe_q;
  assign busy   = (state_q == S_SEARCH);
  assign done   = (state_q == S_DONE);
  assign found  = found_q;
  assign result = result_q;
  assign steps  = steps_q;
`ifdef SAR_SEARCH_CHK_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - self-checking bench for sar_search with a comparator model

module tb_sar_search;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          agb, aeb, alb;
  logic [W-1:0]  probe, result;
  logic          busy, done, found, err;
  logic [CW-1:0] steps;

  logic [W-1:0]  target = '0;
  bit            ovr = 1'b0;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .agb    (agb),
    .aeb    (aeb),
    .alb    (alb),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .result (result),
    .steps  (steps),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Combinational comparator with a target on a, probe on b.
  always_comb begin
    if (ovr) begin
      agb = 1'b1;
      aeb = 1'b0;
      alb = 1'b1;
    end else begin
      agb = (target > probe);
      aeb = (target == probe);
      alb = (target < probe);
    end
  end

  // Reference: plain integer binary search over [0, 2^W-1].
  function automatic void build_exp(input int t);
    int lo, hi, p;
    exp_q.delete();
    lo = 0;
    hi = (1 << W) - 1;
    for (int k = 0; k < 2 * W + 2; k++) begin
      p = (lo + hi) / 2;
      exp_q.push_back(p);
      if (p == t) break;
      if (t > p) lo = p + 1;
      else hi = p - 1;
    end
  endfunction

  // Caller must be at a falling edge; start is raised immediately.
  task automatic run_search(input int t, input bit poke, input string tag);
    int  got[$];
    int  n;
    bit  mism;
    build_exp(t);
    target = W'(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 3 * W) begin
      if (busy) got.push_back(int'(probe));
      start = (poke && n == 1);
      @(negedge clk);
      n++;
    end
    start = 1'b0;

    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s timeout: done=%0b after %0d edges, required 1", tag, done, n);
    end

    mism = (got.size() != exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] != exp_q[i]) mism = 1'b1;
    tests++;
    if (mism) begin
      fails++;
      $display("FAIL %s probe_seq: got %p, required %p", tag, got, exp_q);
    end

    tests++;
    if (n != exp_q.size()) begin
      fails++;
      $display("FAIL %s latency: done after %0d edges past start edge, required %0d", tag, n, exp_q.size());
    end

    tests++;
    if ({busy, found, result, steps, err} !== {1'b0, 1'b1, W'(t), CW'(exp_q.size()), 1'b0}) begin
      fails++;
      $display("FAIL %s outputs: busy=%0b found=%0b result=%0d steps=%0d err=%0b, required 0 1 %0d %0d 0",
               tag, busy, found, result, steps, err, t, exp_q.size());
    end

    @(negedge clk);
    tests++;
    if ({done, busy, found, result} !== {1'b0, 1'b0, 1'b1, W'(t)}) begin
      fails++;
      $display("FAIL %s held: done=%0b busy=%0b found=%0b result=%0d, required 0 0 1 %0d",
               tag, done, busy, found, result, t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({probe, busy, done, found, result, steps, err} !== '0) begin
      fails++;
      $display("FAIL reset_state: probe=%0d busy=%0b done=%0b found=%0b result=%0d steps=%0d err=%0b, required all 0",
               probe, busy, done, found, result, steps, err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({probe, busy, done, found, result, steps, err} !== '0) begin
        fails++;
        $display("FAIL idle_hold[%0d]: probe=%0d busy=%0b done=%0b found=%0b result=%0d steps=%0d err=%0b, required all 0",
                 i, probe, busy, done, found, result, steps, err);
      end
    end
  endtask

  task automatic test_known();
    run_search(7, 1'b0, "target7");
    run_search(15, 1'b0, "target15");
    run_search(0, 1'b1, "target0_start_poke");
  endtask

  task automatic test_abort();
    target = W'(9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, probe} !== {1'b1, W'(11)}) begin
      fails++;
      $display("FAIL abort_second_probe: busy=%0b probe=%0d, required 1 11", busy, probe);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({probe, busy, done, found, result, steps, err} !== '0) begin
      fails++;
      $display("FAIL abort_clear: probe=%0d busy=%0b done=%0b steps=%0d, required all 0", probe, busy, done, steps);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_done[%0d]: done=%0b busy=%0b, required 0 0", i, done, busy);
      end
    end
    run_search(9, 1'b0, "target9_restart");
  endtask

  task automatic test_done_start_ignored();
    int n;
    target = W'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_start timeout: done=%0b, required 1", done);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL done_start_ignored[%0d]: busy=%0b, required 0", i, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    run_search(12, 1'b0, "b2b_a");
    run_search(1, 1'b0, "b2b_b");
    run_search(8, 1'b0, "b2b_c");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      run_search(int'($urandom_range(0, (1 << W) - 1)), bit'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_flag_err();
    int n;
    target = W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ovr = 1'b1;
    @(negedge clk);
    ovr = 1'b0;
`ifdef SAR_SEARCH_CHK_EN
    tests++;
    if ({done, busy, err, found, result, steps} !== {1'b1, 1'b0, 1'b1, 1'b0, W'(0), CW'(1)}) begin
      fails++;
      $display("FAIL flag_err_chk: done=%0b busy=%0b err=%0b found=%0b result=%0d steps=%0d, required 1 0 1 0 0 1",
               done, busy, err, found, result, steps);
    end
    @(negedge clk);
`else
    tests++;
    if ({busy, done, probe} !== {1'b1, 1'b0, W'(11)}) begin
      fails++;
      $display("FAIL flag_err_priority: busy=%0b done=%0b probe=%0d, required 1 0 11", busy, done, probe);
    end
    // Bounds now [8,15] while the real target is 3: probes 11,9,8 then miss.
    n = 0;
    while (!done && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if ({done, found, result, err, steps} !== {1'b1, 1'b0, W'(0), 1'b0, CW'(4)}) begin
      fails++;
      $display("FAIL flag_err_miss: done=%0b found=%0b result=%0d err=%0b steps=%0d, required 1 0 0 0 4",
               done, found, result, err, steps);
    end
    @(negedge clk);
`endif
    run_search(6, 1'b0, "after_flag_err");
  endtask

  initial begin
    test_reset();
    test_known();
    test_abort();
    test_done_start_ignored();
    test_back_to_back();
    test_flag_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
